// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and frame-buffer read sequencer.
// Latency: counter state -> rd_addr/rd_en 1 clock; -> hsync/vsync/de/colour/frame_start RD_LAT+2 clocks.
// Backpressure: none; free-running raster, the frame-buffer read port must return data RD_LAT clocks after rd_en.
//
// Ports:
//   clk, rstn          pixel clock, asynchronous active-low reset
//   scale2             1 = show each buffer pixel as a 2x2 block (latched at frame start)
//   rd_addr, rd_en     frame-buffer read request (rd_en only in the active region)
//   pixel_in           read data {blu,grn,red}, valid RD_LAT clocks after rd_en
//   red, grn, blu, de  colour and display enable to the DAC (colour forced to 0 outside de)
//   hsync, vsync       syncs at HS_POL / VS_POL when asserted
//   frame_start        one-clock pulse with the first active pixel of each frame on the outputs
// Optional: define VGA_TEST_PATTERN_EN to add input pattern_sel, which replaces the frame buffer
// with 8 vertical colour bars (rd_en held low), keeping the same timing.

module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 4,
  parameter int   AW       = 19,
  parameter int   RD_LAT   = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            scale2,
`ifdef VGA_TEST_PATTERN_EN
  input  logic            pattern_sel,
`endif
  output logic [AW-1:0]   rd_addr,
  output logic            rd_en,
  input  logic [3*CW-1:0] pixel_in,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   grn,
  output logic [CW-1:0]   blu,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Buffer pixels per displayed line in each mode.
  localparam logic [AW-1:0] LINE_1X = AW'(H_ACTIVE);
  localparam logic [AW-1:0] LINE_2X = AW'(H_ACTIVE / 2);

  // ---------------------------------------------------------------- raster counters
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          line_end;
  logic          frame_first;

  assign line_end    = (hcnt == H_LAST);
  assign frame_first = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- scale mode
  // s_q is only written on the first pixel of a frame. During that one clock the
  // register still holds the previous frame's mode, so the x stepping decision
  // for that clock must look at scale2 directly.
  logic s_q;
  logic s_cur;

  assign s_cur = frame_first ? scale2 : s_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            s_q <= 1'b0;
    else if (frame_first) s_q <= scale2;
  end

  // ---------------------------------------------------------------- address generation
  // x_cnt tracks hcnt>>s, line_base tracks (vcnt>>s)*(H_ACTIVE>>s); their sum is the
  // read address without a multiplier.
  logic [AW-1:0] x_cnt;
  logic [AW-1:0] line_base;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    x_cnt <= '0;
    else if (line_end)            x_cnt <= '0;
    else if (!s_cur || hcnt[0])   x_cnt <= x_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_base <= '0;
    end else if (line_end) begin
      if (vcnt == V_LAST)
        line_base <= '0;
      else if ((vcnt < V_ACT) && (!s_q || vcnt[0]))
        line_base <= line_base + (s_q ? LINE_2X : LINE_1X);
    end
  end

  // ---------------------------------------------------------------- raster flags
  logic hs_i, vs_i, act_i, fetch;

  assign hs_i  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_i  = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign act_i = (hcnt < H_ACT) && (vcnt < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  assign fetch = act_i & ~pattern_sel;
`else
  assign fetch = act_i;
`endif

  // ---------------------------------------------------------------- read request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= fetch;
      if (fetch) rd_addr <= line_base + x_cnt;
    end
  end

  // ---------------------------------------------------------------- delay line
  // RD_LAT+1 stages here plus the output register make RD_LAT+2 in total; stage
  // RD_LAT is coincident with pixel_in for the same raster position.
  logic [RD_LAT:0] hs_d, vs_d, act_d, fs_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_d  <= '0;
      vs_d  <= '0;
      act_d <= '0;
      fs_d  <= '0;
    end else begin
      hs_d  <= {hs_d[RD_LAT-1:0],  hs_i};
      vs_d  <= {vs_d[RD_LAT-1:0],  vs_i};
      act_d <= {act_d[RD_LAT-1:0], act_i};
      fs_d  <= {fs_d[RD_LAT-1:0],  frame_first & act_i};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // ---------------------------------------------------------------- colour bars
  // bar_k is hcnt / (H_ACTIVE/8) across the active part of the line, built from a
  // position-within-bar counter instead of a divider.
  localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);

  logic [HW-1:0]   bar_pos;
  logic [2:0]      bar_k;
  logic [2:0]      k_d [RD_LAT+1];
  logic [RD_LAT:0] pat_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_pos <= '0;
      bar_k   <= '0;
    end else if (line_end) begin
      bar_pos <= '0;
      bar_k   <= '0;
    end else if (bar_pos == BAR_LAST) begin
      bar_pos <= '0;
      bar_k   <= bar_k + 1'b1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_d <= '0;
      for (int i = 0; i <= RD_LAT; i++) k_d[i] <= '0;
    end else begin
      pat_d  <= {pat_d[RD_LAT-1:0], pattern_sel};
      k_d[0] <= bar_k;
      for (int i = 1; i <= RD_LAT; i++) k_d[i] <= k_d[i-1];
    end
  end
`endif

  // ---------------------------------------------------------------- colour source
  logic [3*CW-1:0] pix;

  always_comb begin
    pix = pixel_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pat_d[RD_LAT])
      pix = {{CW{k_d[RD_LAT][2]}}, {CW{k_d[RD_LAT][1]}}, {CW{k_d[RD_LAT][0]}}};
`endif
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      grn         <= '0;
      blu         <= '0;
    end else begin
      hsync       <= hs_d[RD_LAT] ? HS_POL : ~HS_POL;
      vsync       <= vs_d[RD_LAT] ? VS_POL : ~VS_POL;
      de          <= act_d[RD_LAT];
      frame_start <= fs_d[RD_LAT];
      red         <= act_d[RD_LAT] ? pix[CW-1:0]      : '0;
      grn         <= act_d[RD_LAT] ? pix[2*CW-1:CW]   : '0;
      blu         <= act_d[RD_LAT] ? pix[3*CW-1:2*CW] : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen on a 16x8 raster (8x4 active),
// 1x/2x modes, mid-frame mode change and mid-frame reset, against a raster model.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int CW = 4, AW = 6, RDL = 2;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 8
  localparam int FT = HT * VT;             // 128 clocks per frame
  localparam int LAT = RDL + 2;            // counter -> video outputs

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            scale2 = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  logic            pattern_sel = 1'b0;
`endif
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [3*CW-1:0] pixel_in;
  logic [CW-1:0]   red, grn, blu;
  logic            hsync, vsync, de, frame_start;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .AW(AW), .RD_LAT(RDL)
  ) dut (
    .clk(clk), .rstn(rstn), .scale2(scale2),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_addr(rd_addr), .rd_en(rd_en), .pixel_in(pixel_in),
    .red(red), .grn(grn), .blu(blu),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM model: contents echo the address, RDL clocks of read latency.
  logic [3*CW-1:0] mem_d [RDL];
  always @(posedge clk) begin
    mem_d[0] <= 12'(rd_addr);
    for (int i = 1; i < RDL; i++) mem_d[i] <= mem_d[i-1];
  end
  assign pixel_in = mem_d[RDL-1];

  // cyc = raster position (clocks since the counters left reset)
  int cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------- raster model
  bit sc_hist [0:4095];   // scale2 as driven during each raster clock

  function automatic int hpos(int c); return (c % FT) % HT; endfunction
  function automatic int vpos(int c); return (c % FT) / HT; endfunction
  function automatic bit act(int c);  return hpos(c) < HA && vpos(c) < VA; endfunction
  function automatic int addr_of(int c);
    int s;
    s = int'(sc_hist[c - (c % FT)]);
    return (vpos(c) >> s) * (HA >> s) + (hpos(c) >> s);
  endfunction

  // {hsync, vsync, de, frame_start, blu, grn, red} for raster position c (c<0: reset)
  function automatic int exp_out(int c);
    int h, v;
    logic hs, vs, d, fs;
    logic [11:0] col;
    if (c < 0) return int'({1'b1, 1'b1, 1'b0, 1'b0, 12'd0});
    h   = hpos(c);
    v   = vpos(c);
    hs  = !(h >= HA + HF && h < HA + HF + HS);
    vs  = !(v >= VA + VF && v < VA + VF + VS);
    d   = act(c);
    fs  = (h == 0 && v == 0);
    col = d ? 12'(addr_of(c)) : 12'd0;
    return int'({hs, vs, d, fs, col});
  endfunction

  // ---------------------------------------------------------------- per-cycle compare
  logic [AW-1:0] addr_hold = '0;

  always @(negedge clk) begin : cmp
    int eo, er;
    bit ren;
    if (!rstn) begin
      eo = exp_out(-1);
      addr_hold = '0;
      er = 0;
    end else begin
      sc_hist[cyc] = scale2;
      eo  = exp_out(cyc - LAT);
      ren = (cyc >= 1) && act(cyc - 1);
      if (ren) addr_hold = AW'(addr_of(cyc - 1));
      er  = int'({ren, addr_hold});
    end
    check($sformatf("video@%0d", cyc), int'({hsync, vsync, de, frame_start, blu, grn, red}), eo);
    check($sformatf("rdport@%0d", cyc), int'({rd_en, rd_addr}), er);
  end

  // ---------------------------------------------------------------- literal expectations
  bit          run0 = 1'b0;
  int          hs_low = 0, de_line = 0, vs_low = 0, de_frame = 0, first_de = -1;
  logic [11:0] col_q [$];
  int          rd_q  [$];
  int          line0 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int          roff  [4] = '{0, 0, 4, 4};

  always @(negedge clk) begin : lit
    int mx;
    if (!rstn) begin
      first_de = -1;
    end else begin
      if (de && first_de < 0) first_de = cyc;
      if (cyc == LAT + 1) check("first_de_cycle", first_de, 4);
      if (run0) begin
        if (cyc >= 4 && cyc < 20) begin
          if (!hsync) hs_low++;
          if (de) de_line++;
        end
        if (cyc == 20) begin
          check("hsync_low_per_line", hs_low, 3);
          check("de_per_line", de_line, 8);
        end
        if (cyc == 4) check("frame_start_pixel0", int'({frame_start, de, blu, grn, red}), int'({1'b1, 1'b1, 12'd0}));
        if (cyc >= 4 && cyc < 132) begin
          if (!vsync) vs_low++;
          if (de) begin
            de_frame++;
            col_q.push_back({blu, grn, red});
          end
        end
        if (cyc == 132) begin
          check("vsync_low_per_frame", vs_low, 32);
          check("de_per_frame", de_frame, 32);
          check("colour_count", col_q.size(), 32);
          for (int i = 0; i < col_q.size() && i < 32; i++)
            check($sformatf("colour_seq[%0d]", i), int'(col_q[i]), i);
        end
        if (cyc >= 129 && cyc <= 256 && rd_en) rd_q.push_back(int'(rd_addr));
        if (cyc == 257) begin
          check("rd2x_count", rd_q.size(), 32);
          mx = 0;
          for (int i = 0; i < rd_q.size() && i < 32; i++) begin
            check($sformatf("rd2x_seq[%0d]", i), rd_q[i], line0[i % 8] + roff[i / 8]);
            if (rd_q[i] > mx) mx = rd_q[i];
          end
          check("rd2x_max", mx, 7);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rstn   = 1'b0;
    scale2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    run0 = 1'b1;
    // frame 0 in 1x; request 2x mid-frame (vcnt=2) -> takes effect on frame 1
    repeat (32) @(posedge clk);
    #1 scale2 = 1'b1;
    // frame 1 in 2x; request 1x at its vcnt=2 -> frame 2 back in 1x
    repeat (128) @(posedge clk);
    #1 scale2 = 1'b0;
    // frame 2: reset at vcnt=2, hcnt=5 (raster position 293)
    repeat (133) @(posedge clk);
    #1 rstn = 1'b0;
    run0 = 1'b0;
    #1 check("reset_immediate",
             int'({hsync, vsync, de, frame_start, blu, grn, red, rd_en, rd_addr}),
             int'({1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 6'd0}));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and frame-buffer read sequencer.
- Generalised successor of the fixed 640x480 generator: timing, sync polarity, colour depth and memory read latency are all parameters.
- Adds run-time 1x/2x pixel replication (scaling).
- Sits between the frame-buffer RAM read port and the board VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CW, 4, bits per colour channel
AW, 19, frame-buffer address width
RD_LAT, 1, frame-buffer read latency in clocks (1..4)

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
scale2  in  1  1 = 2x replication (each buffer pixel shown 2x2); sampled at frame start
rd_addr  out  AW  frame-buffer read address
rd_en  out  1  read strobe, high during active region only
pixel_in  in  3*CW  read data {blu,grn,red}, valid RD_LAT clocks after rd_en
red  out  CW  red to DAC
grn  out  CW  green to DAC
blu  out  CW  blue to DAC
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  display enable, aligned with red/grn/blu
frame_start  out  1  one-clock pulse aligned with first active pixel of frame on outputs

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcnt counts 0..H_TOTAL-1 and wraps. vcnt advances when hcnt = H_TOTAL-1 and wraps at V_TOTAL-1.
- Line order: active [0,H_ACTIVE), front porch, sync, back porch. Vertical order is identical, counted in lines.
- Internal hs_i is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs_i is defined the same way on vcnt. Output level = active ? POL : ~POL.
- act_i = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Mode latch: scale2 is captured into s_q only at hcnt=0, vcnt=0. A mid-frame change of scale2 has no effect until the next frame.
- Address rule: rd_addr = (vcnt>>s_q)*(H_ACTIVE>>s_q) + (hcnt>>s_q). Generated incrementally, no multiplier:
  - line_base register is reset to 0 at frame start.
  - line_base += H_ACTIVE>>s_q at end of each active line. When s_q=1, this happens only after odd lines.
  - x counter steps every clock (s_q=0) or every 2nd clock (s_q=1).
- Pipeline: counter state at cycle t gives rd_addr/rd_en registered at t+1. pixel_in is consumed at t+1+RD_LAT. Outputs are registered at t+2+RD_LAT.
- hs_i, vs_i, act_i and the frame-start flag pass through an RD_LAT+2 stage delay line so sync, de and colour stay aligned.
- Outside de, red/grn/blu = 0 regardless of pixel_in.
- rd_addr holds its last value when rd_en = 0. It is never driven beyond V_ACTIVE*H_ACTIVE-1 in 1x mode.
- Reset values:
  - hcnt, vcnt, line_base, rd_addr: 0
  - rd_en, de, frame_start: 0
  - red, grn, blu: 0
  - hsync: ~HS_POL; vsync: ~VS_POL
  - s_q: 0
  - all delay-line stages: inactive
- Reset mid-frame: all outputs return to reset values immediately. Counting restarts at hcnt=vcnt=0 on the first clock after deassertion.
- Odd H_ACTIVE in 2x mode is unsupported. Parameters must satisfy H_ACTIVE and V_ACTIVE even.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN adds input pattern_sel (1 bit).
- With the macro defined and pattern_sel=1:
  - pixel_in is ignored and rd_en is forced to 0.
  - Output colour is 8 vertical bars, each H_ACTIVE/8 wide. Bar index k (0..7) drives red = {CW{k[0]}}, grn = {CW{k[1]}}, blu = {CW{k[2]}}.
  - Timing and latency are unchanged.
- Without the macro: port absent, behaviour as above.

Test Plan:
- Small timing (H 8/2/3/3, V 4/1/2/1, HS_POL=VS_POL=0) -> hsync low exactly 3 clocks per 16. vsync low exactly 2 lines (32 clocks) per 8 lines. de high 8 clocks per line on 4 lines.
- 1x mode, RD_LAT=2, pixel_in = address echo from model RAM -> red/grn/blu show 0..31 in order. de rises exactly 4 clocks after act_i. frame_start coincides with pixel 0.
- 2x mode -> each address appears on 2 consecutive clocks and on 2 consecutive lines. Address sequence per frame: 0,0,1,1,2,2,3,3 twice, then 4..7 likewise. Max address 7.
- Toggle scale2 at vcnt=2 -> current frame unchanged; next frame uses new mode.
- Assert rstn low at vcnt=2, hcnt=5 for 3 clocks -> outputs go to reset values immediately. First de after release is 2+RD_LAT clocks after hcnt=0, vcnt=0.
- VGA_TEST_PATTERN_EN, pattern_sel=1, H_ACTIVE=16 -> colour changes every 2 pixels through 0,R,G,RG,B,RB,GB,RGB. rd_en stays 0.
